// File: rtl/calc_program_loader.sv
// Writer side of the calculator instruction interface: buffers op/A/B entries,
// then resets the calculator, streams DEPTH words and waits out execution.
module calc_program_loader #(
  parameter int DEPTH       = 16,
  parameter int EXEC_CYCLES = 17
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  input  logic                     start,
  output logic                     calc_reset,
  output logic [17:0]              dout,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EXE_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [PTR_W-1:0] K_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [EXE_W-1:0] E_LAST  = EXE_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  typedef enum logic [2:0] {IDLE, RST, STREAM, EXEC, DONE} state_t;

  state_t            state_q;
  logic [PTR_W-1:0]  k_q;
  logic [EXE_W-1:0]  e_q;
  logic [CNT_W-1:0]  count_q;
  logic              calc_reset_q;
  logic [17:0]       dout_q;
  logic              busy_q;
  logic              done_q;
  logic [17:0]       mem_q [DEPTH];

  logic              accept;
  logic [CNT_W-1:0]  k_nxt_d;

  assign in_ready = (state_q == IDLE) && (count_q < CNT_MAX);
  assign accept   = in_valid && in_ready;
  assign k_nxt_d  = {1'b0, k_q} + CNT_W'(1);

  assign calc_reset = calc_reset_q;
  assign dout       = dout_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign count      = count_q;

  // Instruction buffer: payload only, never reset.
  always_ff @(posedge clk) begin
    if (accept) mem_q[count_q[PTR_W-1:0]] <= {in_op, in_a, in_b};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      e_q          <= '0;
      count_q      <= '0;
      calc_reset_q <= 1'b1;
      dout_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) count_q <= count_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          // count_q here is the pre-accept value; a same-cycle entry still joins the run
          if (start && (count_q != '0)) begin
            state_q      <= RST;
            calc_reset_q <= 1'b1;
            dout_q       <= mem_q[0];
            busy_q       <= 1'b1;
          end
        end
        RST: begin
          state_q      <= STREAM;
          k_q          <= '0;
          calc_reset_q <= 1'b0;
          dout_q       <= mem_q[0];
        end
        STREAM: begin
          if (k_q == K_LAST) begin
            state_q <= EXEC;
            e_q     <= '0;
            dout_q  <= '0;
          end else begin
            k_q    <= k_nxt_d[PTR_W-1:0];
            dout_q <= (k_nxt_d < count_q) ? mem_q[k_nxt_d[PTR_W-1:0]] : 18'h0;
          end
        end
        EXEC: begin
          if (e_q == E_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            count_q <= '0;
          end else begin
            e_q <= e_q + EXE_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/calc_program_loader.md
Name: calc_program_loader

Overview:
- Writer end of the Calculator instruction interface.
- Accepts op/A/B entries over a valid/ready handshake and packs each into an 18-bit instruction word {op[1:0], a[7:0], b[7:0]}.
- Buffers up to DEPTH words. On start, pulses the calculator reset, then streams exactly DEPTH words on consecutive cycles.
- Waits out the calculator's execution window, then signals done.

Parameters:
- DEPTH, 16, instruction slots streamed per run; must match the calculator memory depth.
- EXEC_CYCLES, 17, cycles to wait after the last streamed word before done.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  entry present on in_op/in_a/in_b.
- in_ready  output  1  loader can accept an entry this cycle.
- in_op  input  2  ALU opcode.
- in_a  input  8  operand A.
- in_b  input  8  operand B.
- start  input  1  begin a run, single-cycle pulse.
- calc_reset  output  1  drives the calculator reset.
- dout  output  18  instruction word to the calculator DIN.
- busy  output  1  run in progress (any state other than IDLE).
- done  output  1  one-cycle pulse at the end of a run.
- count  output  5  number of buffered entries, 0..DEPTH.

Behaviour:
- Reset (async): state=IDLE, count=0, calc_reset=1, dout=0, busy=0, done=0. Buffer contents are don't-care. Reset mid-run aborts immediately; no done pulse.
- All outputs are registered except in_ready.
- in_ready = (state==IDLE) && (count<DEPTH).
- Accept: on a cycle with in_valid && in_ready, the word {in_op,in_a,in_b} is written to slot count, and count increments.
- IDLE:
  - start && count>0 → RST. An entry accepted in the same cycle is included in the run.
  - start && count==0 → ignored; stay in IDLE.
  - calc_reset=0 in IDLE (after the first run), dout=0.
- RST (exactly 1 cycle): calc_reset=1, dout=slot0 word pre-loaded. → STREAM with k=0.
- STREAM (DEPTH cycles, k=0..DEPTH-1):
  - calc_reset=0.
  - dout = slot k if k<count, else 18'h0 (pad word).
  - Word k is stable for the whole k-th cycle after calc_reset falls, so the downstream edge that ends that cycle samples word k.
  - After k=DEPTH-1 → EXEC.
- EXEC (EXEC_CYCLES cycles): dout=0, calc_reset=0, wait counter runs. On expiry → DONE.
- DONE (1 cycle): done=1, count cleared to 0. → IDLE.
- start and in_valid outside IDLE are ignored. in_ready=0, so no entries are lost silently.
- Full buffer: count==DEPTH deasserts in_ready; start is still honoured.
- Pointer and counter widths: k and the read pointer are clog2(DEPTH) bits. The EXEC counter is sized for EXEC_CYCLES. count is one bit wider than the pointer, so DEPTH itself is representable.
- No arithmetic on the payload; fields are concatenated only.

Test Plan:
- Reset, then push 3 entries ({1,5,3},{2,7,9},{3,4,2}), start → calc_reset high 1 cycle; dout sequence = 0x10503, 0x20709, 0x30402, then 13×0x00000. done asserts exactly 1+16+17+1 cycles after start, and count returns to 0.
- Push 16 entries with in_valid held high → in_ready drops after the 16th. A 17th entry is held, not accepted, and count=16. start streams all 16 in order.
- start with count==0 → no state change; busy stays 0; calc_reset is not pulsed.
- start coincident with an accepted entry (count=2→3) → the run streams 3 real words plus 13 pad words.
- Assert reset during STREAM at k=5 → all outputs go immediately to reset values; no done pulse. A subsequent fill and start runs normally.
- in_valid and start pulsed during EXEC → no accept, no restart, count unchanged until DONE clears it.
